bpu_fetch_queue: RTL and testbench

- Elastic FIFO between the branch predictor and instruction-fetch (ICache) stage.
- Buffers predicted fetch packets: fetch-block PC, 2-bit slot mask, and packed per-slot prediction payload.
- Decouples the 1-packet-per-cycle predictor from fetch stalls.
- A redirect flush drops every buffered packet, together with the predictor's own PC redirect.

---
 rtl/bpu_fetch_queue.sv | 88 ++++++++
 tb/tb_bpu_fetch_queue.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bpu_fetch_queue.sv
// Elastic fetch-packet FIFO from branch predictor to ICache fetch; optional macro BPU_FETCH_QUEUE_BYPASS_EN.
// Latency: 1 cycle push-to-head (0 cycles when empty with bypass enabled); 1 packet/cycle throughput.
// Backpressure: in_ready_o = !full from registered pointers only; flush_i drops everything and wins over push/pop.
module bpu_fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int PRED_W = 128,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_pc_i,
    input  logic [1:0]        in_mask_i,
    input  logic [PRED_W-1:0] in_pred_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_pc_o,
    output logic [1:0]        out_mask_o,
    output logic [PRED_W-1:0] out_pred_o,
    output logic [CNT_W-1:0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]       r_pc_mem   [DEPTH];
    logic [1:0]        r_mask_mem [DEPTH];
    logic [PRED_W-1:0] r_pred_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;
    logic [AW:0]       w_occ;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_occ    = r_wr_ptr - r_rd_ptr;

    assign in_ready_o = !w_full;
    assign count_o    = CNT_W'(w_occ);
    assign w_pop      = !w_empty && out_ready_i && !flush_i;

`ifdef BPU_FETCH_QUEUE_BYPASS_EN
    logic w_byp_take;

    // An empty queue forwards the incoming packet; it is stored only if fetch stalls.
    assign w_byp_take  = w_empty && in_valid_i && out_ready_i && !flush_i;
    assign w_push      = in_valid_i && !w_full && !flush_i && !w_byp_take;
    assign out_valid_o = w_empty ? (in_valid_i && !flush_i) : 1'b1;
    assign out_pc_o    = w_empty ? in_pc_i   : r_pc_mem[w_rd_idx];
    assign out_mask_o  = w_empty ? in_mask_i : r_mask_mem[w_rd_idx];
    assign out_pred_o  = w_empty ? in_pred_i : r_pred_mem[w_rd_idx];
`else
    assign w_push      = in_valid_i && !w_full && !flush_i;
    assign out_valid_o = !w_empty;
    assign out_pc_o    = r_pc_mem[w_rd_idx];
    assign out_mask_o  = r_mask_mem[w_rd_idx];
    assign out_pred_o  = r_pred_mem[w_rd_idx];
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[w_wr_idx]   <= in_pc_i;
            r_mask_mem[w_wr_idx] <= in_mask_i;
            r_pred_mem[w_wr_idx] <= in_pred_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_bpu_fetch_queue.sv
// Directed bench for bpu_fetch_queue: packet-queue model checked every negedge plus literal spot checks.
module tb_bpu_fetch_queue;
    localparam int DEPTH  = 8;
    localparam int PRED_W = 128;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              flush_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [31:0]       in_pc_i = '0;
    logic [1:0]        in_mask_i = '0;
    logic [PRED_W-1:0] in_pred_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [31:0]       out_pc_o;
    logic [1:0]        out_mask_o;
    logic [PRED_W-1:0] out_pred_o;
    logic [CNT_W-1:0]  count_o;

    bpu_fetch_queue #(.DEPTH(DEPTH), .PRED_W(PRED_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_mask_i(in_mask_i), .in_pred_i(in_pred_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_mask_o(out_mask_o), .out_pred_o(out_pred_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       pc;
        logic [1:0]        mask;
        logic [PRED_W-1:0] pred;
    } pkt_t;

    pkt_t mq[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;

    function automatic logic [PRED_W-1:0] pred_of(input logic [31:0] pc);
        return {pc ^ 32'hA5A5A5A5, ~pc, pc, pc + 32'h1234};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference queue: a packet is accepted when there is room before this edge's pop.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else if (flush_i) begin
            mq.delete();
        end else begin
            bit do_push, do_pop;
            pkt_t p;
            do_push = in_valid_i && (mq.size() < DEPTH);
            do_pop  = out_ready_i && (mq.size() > 0);
            p.pc = in_pc_i; p.mask = in_mask_i; p.pred = in_pred_i;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(p);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", {159'd0, out_valid_o}, {159'd0, mq.size() != 0});
            check("model_ready", {159'd0, in_ready_o}, {159'd0, mq.size() < DEPTH});
            check("model_count", 160'(count_o), 160'(mq.size()));
            if (mq.size() != 0) begin
                check("model_pc", 160'(out_pc_o), 160'(mq[0].pc));
                check("model_mask", 160'(out_mask_o), 160'(mq[0].mask));
                check("model_pred", 160'(out_pred_o), 160'(mq[0].pred));
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [1:0] m,
                       input logic ordy, input logic fl);
        in_valid_i  = v;
        in_pc_i     = pc;
        in_mask_i   = m;
        in_pred_i   = pred_of(pc);
        out_ready_i = ordy;
        flush_i     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_count", 160'(count_o), 160'd0);
        check("rst_async_valid", {159'd0, out_valid_o}, 160'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk_en = 1'b1;
        check("rst_ready", {159'd0, in_ready_o}, 160'd1);
        check("rst_count", 160'(count_o), 160'd0);

        // Three pushes held at the head by a stalled fetch stage
        for (int i = 0; i < 3; i++) cyc(1, 32'h1c000000 + 32'(8 * i), 2'(i + 1), 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("hold_count", 160'(count_o), 160'd3);
        check("hold_pc", 160'(out_pc_o), 160'h1c000000);
        for (int i = 0; i < 3; i++) begin
            check("drain_pc", 160'(out_pc_o), 160'(32'h1c000000 + 32'(8 * i)));
            cyc(0, 0, 0, 1, 0);
        end
        check("drain_empty", {159'd0, out_valid_o}, 160'd0);

        // Fill, then push+pop while full: only the pop lands
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'h1c001000 + 32'(8 * i), 2'(i), 0, 0);
        check("full_count", 160'(count_o), 160'd8);
        check("full_ready", {159'd0, in_ready_o}, 160'd0);
        cyc(1, 32'h1c0010f0, 2'b11, 1, 0);
        check("fullpop_count", 160'(count_o), 160'd7);
        check("fullpop_ready", {159'd0, in_ready_o}, 160'd1);
        check("fullpop_head", 160'(out_pc_o), 160'h1c001008);
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 0, 1, 0);
        check("fullpop_drained", 160'(count_o), 160'd0);

        // Streaming push+pop across pointer wrap
        cyc(1, 32'h1c002000, 2'b00, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 32'h1c002000 + 32'(8 * i), 2'(i), 1, 0);
            check("stream_count", 160'(count_o), 160'd1);
        end
        check("stream_last", 160'(out_pc_o), 160'h1c0020a0);
        cyc(0, 0, 0, 1, 0);

        // Flush with five queued and a concurrent push and pop
        for (int i = 0; i < 5; i++) cyc(1, 32'h1c003000 + 32'(8 * i), 2'b01, 0, 0);
        check("preflush_count", 160'(count_o), 160'd5);
        cyc(1, 32'h1c0030f8, 2'b10, 1, 1);
        check("flush_count", 160'(count_o), 160'd0);
        check("flush_valid", {159'd0, out_valid_o}, 160'd0);
        cyc(1, 32'h1c004000, 2'b11, 0, 0);
        check("postflush_pc", 160'(out_pc_o), 160'h1c004000);
        check("postflush_count", 160'(count_o), 160'd1);

        // Asynchronous reset while holding packets
        cyc(1, 32'h1c004008, 2'b01, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", 160'(count_o), 160'd0);
        check("midrst_valid", {159'd0, out_valid_o}, 160'd0);
        #2 rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check("midrst_ready", {159'd0, in_ready_o}, 160'd1);
        pc = 32'h1c005000;
        cyc(1, pc, 2'b10, 0, 0);
        check("midrst_push_pc", 160'(out_pc_o), 160'(pc));
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
